// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared types and constants for the HDLC transmit path
package hdlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_OPEN_FLAG  = 3'd1,
        ST_DATA       = 3'd2,
        ST_FCS        = 3'd3,
        ST_CLOSE_FLAG = 3'd4,
        ST_ABORT      = 3'd5
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_R  = 16'h8408;
    localparam logic [2:0]  STUFF_LIMIT = 3'd5;

endpackage

// File: rtl/hdlc_tx_crc16.sv
// rtl/hdlc_tx_crc16.sv - bit-serial reflected CRC-16 (X.25) accumulator
module hdlc_tx_crc16
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_bit,
    output logic [15:0] crc
);

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= {1'b0, crc[15:1]} ^ ((crc[0] ^ data_bit) ? CRC_POLY_R : 16'h0000);
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - HDLC transmit framer with flags, zero stuffing, FCS and abort
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter bit FCS_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_DataLast,
    output logic       Tx_DataReady,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    tx_state_t   state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n, cnt_inc, bit_top;
    logic [15:0] shreg, shreg_n;
    logic [2:0]  ones, ones_n;
    logic        last_byte, last_byte_n;
    logic        tx_n, valid_n, done_n, aborted_n;
    logic        crc_clr, crc_en, crc_bit, nbit;
    logic        stuff_due, abort_req, need_byte;
    logic [15:0] crc;

    hdlc_tx_crc16 u_crc (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (crc_clr),
        .enable   (crc_en),
        .data_bit (crc_bit),
        .crc      (crc)
    );

    // bit_cnt always indexes the data bit most recently placed on Tx; a stuffed zero leaves it unchanged
    assign cnt_inc   = bit_cnt + 4'd1;
    assign bit_top   = (state == ST_FCS) ? 4'd15 : 4'd7;
    assign stuff_due = (ones == STUFF_LIMIT);
    assign abort_req = Tx_AbortFrame &&
                       (state == ST_OPEN_FLAG || state == ST_DATA || state == ST_FCS);
    assign need_byte = !abort_req && (bit_cnt == 4'd7) &&
                       ((state == ST_OPEN_FLAG) ||
                        (state == ST_DATA && !last_byte && !stuff_due));
    assign Tx_DataReady = need_byte && !Rst;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        ones_n      = ones;
        last_byte_n = last_byte;
        tx_n        = Tx;
        valid_n     = Tx_ValidFrame;
        done_n      = 1'b0;
        aborted_n   = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;
        nbit        = 1'b0;

        if (abort_req || (need_byte && !Tx_DataValid)) begin
            state_n   = ST_ABORT;
            bit_cnt_n = 4'd0;
            ones_n    = 3'd0;
            tx_n      = 1'b0;
            valid_n   = 1'b0;
            aborted_n = 1'b1;
        end else if (need_byte) begin
            state_n     = ST_DATA;
            shreg_n     = {8'h00, Tx_Data};
            last_byte_n = Tx_DataLast;
            bit_cnt_n   = 4'd0;
            tx_n        = Tx_Data[0];
            ones_n      = Tx_Data[0] ? ones + 3'd1 : 3'd0;
            crc_en      = 1'b1;
            crc_bit     = Tx_Data[0];
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_n    = 1'b1;
                    valid_n = 1'b0;
                    if (Tx_Start) begin
                        state_n   = ST_OPEN_FLAG;
                        bit_cnt_n = 4'd0;
                        ones_n    = 3'd0;
                        tx_n      = HDLC_FLAG[0];
                        valid_n   = 1'b1;
                        crc_clr   = 1'b1;
                    end
                end
                ST_OPEN_FLAG, ST_CLOSE_FLAG: begin
                    if (bit_cnt != 4'd7) begin
                        bit_cnt_n = cnt_inc;
                        tx_n      = HDLC_FLAG[cnt_inc[2:0]];
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end
                end
                ST_DATA, ST_FCS: begin
                    if (stuff_due) begin
                        tx_n   = 1'b0;
                        ones_n = 3'd0;
                    end else if (bit_cnt != bit_top) begin
                        nbit      = shreg[cnt_inc];
                        bit_cnt_n = cnt_inc;
                        tx_n      = nbit;
                        ones_n    = nbit ? ones + 3'd1 : 3'd0;
                        crc_en    = (state == ST_DATA);
                        crc_bit   = nbit;
                    end else if (state == ST_DATA && FCS_EN) begin
                        // the CRC register already holds the last payload bit here
                        state_n   = ST_FCS;
                        shreg_n   = ~crc;
                        bit_cnt_n = 4'd0;
                        tx_n      = ~crc[0];
                        ones_n    = ~crc[0] ? ones + 3'd1 : 3'd0;
                    end else begin
                        state_n   = ST_CLOSE_FLAG;
                        bit_cnt_n = 4'd0;
                        ones_n    = 3'd0;
                        tx_n      = HDLC_FLAG[0];
                    end
                end
                ST_ABORT: begin
                    tx_n = 1'b1;
                    if (bit_cnt != 4'd7) begin
                        bit_cnt_n = cnt_inc;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= ST_IDLE;
            bit_cnt         <= 4'd0;
            shreg           <= 16'h0000;
            ones            <= 3'd0;
            last_byte       <= 1'b0;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
        end else begin
            state           <= state_n;
            bit_cnt         <= bit_cnt_n;
            shreg           <= shreg_n;
            ones            <= ones_n;
            last_byte       <= last_byte_n;
            Tx              <= tx_n;
            Tx_ValidFrame   <= valid_n;
            Tx_Done         <= done_n;
            Tx_AbortedTrans <= aborted_n;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - self-checking bench for hdlc_tx_framer against a bit-list frame model
module tb_hdlc_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, start0, abort_frame, valid, last, sel0;
    logic [7:0] data;
    logic       tx1, vf1, rdy1, done1, abt1;
    logic       tx0, vf0, rdy0, done0, abt0;
    logic       o_tx, o_vf, o_rdy, o_done, o_abt;

    int checks = 0;
    int errors = 0;

    hdlc_tx_framer #(.FCS_EN(1'b1)) dut (
        .Clk(clk), .Rst(rst), .Tx_Start(start1), .Tx_Data(data), .Tx_DataValid(valid),
        .Tx_DataLast(last), .Tx_DataReady(rdy1), .Tx_AbortFrame(abort_frame), .Tx(tx1),
        .Tx_ValidFrame(vf1), .Tx_Done(done1), .Tx_AbortedTrans(abt1));

    hdlc_tx_framer #(.FCS_EN(1'b0)) dut0 (
        .Clk(clk), .Rst(rst), .Tx_Start(start0), .Tx_Data(data), .Tx_DataValid(valid),
        .Tx_DataLast(last), .Tx_DataReady(rdy0), .Tx_AbortFrame(abort_frame), .Tx(tx0),
        .Tx_ValidFrame(vf0), .Tx_Done(done0), .Tx_AbortedTrans(abt0));

    assign o_tx   = sel0 ? tx0   : tx1;
    assign o_vf   = sel0 ? vf0   : vf1;
    assign o_rdy  = sel0 ? rdy0  : rdy1;
    assign o_done = sel0 ? done0 : done1;
    assign o_abt  = sel0 ? abt0  : abt1;

    // per-cycle expectation {tx, valid_frame, ready, done, aborted}
    logic [7:0]  payload[$];
    logic [4:0]  exp_q[$];
    int          start_st[$];
    int          close_start, stuffed_len;
    logic [15:0] exp_fcs, rx_fcs;
    bit          obs_line[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input bit fcs);
        bit bits[$];
        bit st[$];
        logic [15:0] c = 16'hFFFF;
        logic [7:0] flag = 8'h7E;
        logic [4:0] e;
        int ones = 0;
        exp_q.delete();
        start_st.delete();
        foreach (payload[k]) begin
            for (int j = 0; j < 8; j++) begin
                bits.push_back(payload[k][j]);
                c = (c >> 1) ^ ((c[0] ^ payload[k][j]) ? 16'h8408 : 16'h0000);
            end
        end
        exp_fcs = ~c;
        if (fcs) for (int j = 0; j < 16; j++) bits.push_back(exp_fcs[j]);
        foreach (bits[i]) begin
            if (i % 8 == 0 && i / 8 < payload.size()) start_st.push_back(st.size());
            st.push_back(bits[i]);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 5) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        stuffed_len = st.size();
        close_start = 8 + stuffed_len;
        for (int j = 0; j < 8; j++) exp_q.push_back({flag[j], 1'b1, 3'b000});
        foreach (st[i]) exp_q.push_back({st[i], 1'b1, 3'b000});
        for (int j = 0; j < 8; j++) exp_q.push_back({flag[j], 1'b1, 3'b000});
        exp_q.push_back(5'b10010);
        exp_q.push_back(5'b10000);
        foreach (start_st[k]) begin
            e = exp_q[start_st[k] + 7];
            e[2] = 1'b1;
            exp_q[start_st[k] + 7] = e;
        end
    endtask

    task automatic apply_abort(input int cyc, input bit underrun);
        logic [4:0] e;
        if (!underrun) begin
            e = exp_q[cyc];
            e[2] = 1'b0;
            exp_q[cyc] = e;
        end
        while (exp_q.size() > cyc + 1) void'(exp_q.pop_back());
        exp_q.push_back(5'b00001);
        repeat (8) exp_q.push_back(5'b10000);
    endtask

    // abort_byte >= 0: abort_off bits into that payload byte; -2: abort_off from closing flag; -1: absolute cycle
    task automatic run_frame(input string tag, input bit use0, input int abort_byte, input int abort_off,
                             input int under_byte, input bit abort_with_start);
        int idx = 0;
        int abort_cyc;
        bit aborted = 0;
        logic [4:0] o;
        logic [7:0] rx[$];
        logic [7:0] cur = 8'h00;
        int nb = 0, ones = 0;
        bit skip = 0;
        int n;
        n = payload.size();
        build(!use0);
        if (abort_byte >= 0) abort_cyc = start_st[abort_byte] + 8 + abort_off;
        else if (abort_byte == -2) abort_cyc = close_start + abort_off;
        else abort_cyc = abort_off;
        if (under_byte >= 0) begin
            apply_abort(start_st[under_byte] + 7, 1'b1);
            aborted = 1;
        end else if (abort_cyc >= 0 && abort_cyc < close_start) begin
            apply_abort(abort_cyc, 1'b0);
            aborted = 1;
        end
        obs_line.delete();
        sel0 = use0;
        if (use0) start0 = 1'b1; else start1 = 1'b1;
        abort_frame = abort_with_start;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            abort_frame = (i == abort_cyc);
            valid = (idx < n) && (idx != under_byte);
            data  = (idx < n) ? payload[idx] : 8'h00;
            last  = (idx == n - 1);
            @(negedge clk);
            o = {o_tx, o_vf, o_rdy, o_done, o_abt};
            check($sformatf("%s cyc%0d {tx,vf,rdy,done,abt}", tag, i), o, exp_q[i]);
            obs_line.push_back(o_tx);
            if (o_rdy && valid) idx++;
            @(posedge clk); #1;
        end
        abort_frame = 1'b0;
        valid = 1'b0;
        last = 1'b0;
        if (!aborted) begin
            for (int i = 8; i < 8 + stuffed_len; i++) begin
                if (skip) begin
                    skip = 0;
                    continue;
                end
                cur[nb] = obs_line[i];
                nb++;
                if (nb == 8) begin
                    rx.push_back(cur);
                    nb = 0;
                end
                ones = obs_line[i] ? ones + 1 : 0;
                if (ones == 5) begin
                    skip = 1;
                    ones = 0;
                end
            end
            check($sformatf("%s rx_len", tag), rx.size(), n + (use0 ? 0 : 2));
            foreach (payload[k]) if (k < rx.size()) check($sformatf("%s rx_byte%0d", tag, k), rx[k], payload[k]);
            if (!use0 && rx.size() >= n + 2) begin
                rx_fcs = {rx[n + 1], rx[n]};
                check($sformatf("%s rx_fcs", tag), rx_fcs, exp_fcs);
            end
        end
    endtask

    initial begin
        bit        stuff7e[9] = '{0, 1, 1, 1, 1, 1, 0, 1, 0};
        int        n, kind;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort_frame = 1'b0;
        valid = 1'b0; last = 1'b0; data = 8'h00; sel0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dut", {tx1, vf1, rdy1, done1, abt1}, 5'b10000);
        check("reset dut0", {tx0, vf0, rdy0, done0, abt0}, 5'b10000);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle cyc%0d", i), {tx1, vf1, rdy1, done1, abt1}, 5'b10000);
            @(posedge clk); #1;
        end

        payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame("ref", 0, -1, -1, -1, 0);
        check("ref fcs_lo", rx_fcs[7:0], 8'h6E);
        check("ref fcs_hi", rx_fcs[15:8], 8'h90);

        payload = '{8'hFF, 8'hFF};
        run_frame("stuff", 0, -1, -1, -1, 0);

        payload.delete();
        repeat (5) payload.push_back(8'($urandom));
        run_frame("abort_b3", 0, 2, 3, -1, 0);

        payload.delete();
        repeat (3) payload.push_back(8'($urandom));
        run_frame("underrun", 0, -1, -1, 1, 0);

        payload = '{8'hA5, 8'h3C};
        run_frame("start_abort", 0, -1, -1, -1, 1);

        payload = '{8'h0F, 8'hF8};
        run_frame("close_abort", 0, -2, 3, -1, 0);

        payload = '{8'hC3, 8'h7E, 8'hFF};
        run_frame("fcs_abort", 0, -2, -4, -1, 0);

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 6);
            payload.delete();
            repeat (n) payload.push_back(8'($urandom));
            kind = $urandom_range(0, 3);
            if (kind == 2)
                run_frame($sformatf("rnd%0d", f), 0, $urandom_range(0, n - 1), $urandom_range(0, 7), -1, 0);
            else if (kind == 3)
                run_frame($sformatf("rnd%0d", f), 0, -1, -1, $urandom_range(0, n - 1), 0);
            else
                run_frame($sformatf("rnd%0d", f), 0, -1, -1, -1, 0);
        end

        sel0 = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        valid = 1'b1;
        last = 1'b0;
        data = 8'($urandom);
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("rst_mid outputs", {tx1, vf1, rdy1, done1, abt1}, 5'b10000);
        @(posedge clk); #1;
        payload = '{8'h5A, 8'hFE, 8'h01};
        run_frame("post_rst", 0, -1, -1, -1, 0);

        payload = '{8'h7E};
        run_frame("nofcs_7e", 1, -1, -1, -1, 0);
        for (int i = 0; i < 9; i++) check($sformatf("nofcs_7e bit%0d", i), obs_line[8 + i], stuff7e[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
